// File: rtl/aes_mode_ctrl.sv
// rtl/aes_mode_ctrl.sv - APB block-chaining front end (ECB/CBC, CTR when AES_CTR_MODE_EN) for an external AES core
module aes_mode_ctrl #(
  parameter int PINDEX  = 0,
  parameter int NAPBSLV = 8,
  parameter int CTR_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               vclk,
  input  logic               vrst,
  input  logic [NAPBSLV-1:0] vpsel,
  input  logic               vpenable,
  input  logic [31:0]        vpaddr,
  input  logic               vpwrite,
  input  logic [31:0]        vpwdata,
  output logic [31:0]        vprdata,
  output logic               irq,
  output logic               core_ld,
  output logic [127:0]       core_key,
  output logic [127:0]       core_text_in,
  input  logic [127:0]       core_text_out,
  input  logic               core_done
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t            state_q;
  logic [127:0]      key_q, din_q, iv_q, dout_q;
  logic [127:0]      core_text_in_q;
  logic              core_ld_q;
  logic [1:0]        mode_q;
  logic              irq_en_q, done_q, err_q, tmo_q, irq_q;
  logic [31:0]       blkcnt_q;
  logic [WD_W-1:0]   wdog_q;

  logic              irq_en_d, done_d, err_d, tmo_d, irq_d;
  logic [5:0]        idx;
  logic              wr, busy, start_req, start_ok, start_bad, cfg_drop, fin, tmo_evt, w1c;
  logic [127:0]      ld_text, res_dout, res_iv;
  logic              unused_apb;

  function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] i,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = v;
    case (i)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[127:96];
      2'd1:    return v[95:64];
      2'd2:    return v[63:32];
      default: return v[31:0];
    endcase
  endfunction

  function automatic logic mode_legal(input logic [1:0] m);
    case (m)
      2'b00, 2'b01: return 1'b1;
`ifdef AES_CTR_MODE_EN
      2'b10:        return 1'b1;
`endif
      default:      return 1'b0;
    endcase
  endfunction

`ifdef AES_CTR_MODE_EN
  function automatic logic [127:0] ctr_inc(input logic [127:0] v);
    logic [127:0] r;
    r = v;
    r[CTR_W-1:0] = v[CTR_W-1:0] + CTR_W'(1);
    return r;
  endfunction
`endif

  assign idx          = vpaddr[7:2];
  assign unused_apb   = ^{vpaddr[31:8], vpaddr[1:0], vpsel};
  assign core_key     = key_q;
  assign core_ld      = core_ld_q;
  assign core_text_in = core_text_in_q;
  assign irq          = irq_q;

  // Bus decode and status next-state; a set in the same cycle as a W1C clear wins
  always_comb begin
    wr        = vpsel[PINDEX] & vpenable & vpwrite;
    busy      = (state_q != S_IDLE);
    start_req = wr & (idx == 6'd16) & vpwdata[0];
    start_ok  = start_req & ~busy & mode_legal(vpwdata[2:1]);
    start_bad = start_req & ~busy & ~mode_legal(vpwdata[2:1]);
    cfg_drop  = wr & busy & ((idx < 6'd12) | (idx == 6'd16));
    fin       = (state_q == S_WAIT) & core_done;
    tmo_evt   = (state_q == S_WAIT) & ~core_done & (wdog_q == WD_W'(TIMEOUT - 1));
    w1c       = wr & (idx == 6'd17);
    done_d    = fin | (done_q & ~(w1c & vpwdata[1]) & ~start_ok);
    err_d     = cfg_drop | start_bad | tmo_evt | (err_q & ~(w1c & vpwdata[2]));
    tmo_d     = tmo_evt | (tmo_q & ~(w1c & vpwdata[3]));
    irq_en_d  = (wr & ~busy & (idx == 6'd16)) ? vpwdata[3] : irq_en_q;
    irq_d     = irq_en_d & (done_d | err_d);
  end

  // Core input selection at start and result post-processing per chaining mode
  always_comb begin
    ld_text  = din_q;
    res_dout = core_text_out;
    res_iv   = iv_q;
    case (vpwdata[2:1])
      2'b01:   ld_text = din_q ^ iv_q;
`ifdef AES_CTR_MODE_EN
      2'b10:   ld_text = iv_q;
`endif
      default: ld_text = din_q;
    endcase
    case (mode_q)
      2'b01:   res_iv = core_text_out;
`ifdef AES_CTR_MODE_EN
      2'b10: begin
        res_dout = core_text_out ^ din_q;
        res_iv   = ctr_inc(iv_q);
      end
`endif
      default: res_iv = iv_q;
    endcase
  end

  // Combinational register read-back, independent of select
  always_comb begin
    vprdata = 32'd0;
    case (idx[5:2])
      4'd0: vprdata = get_word(key_q, idx[1:0]);
      4'd1: vprdata = get_word(din_q, idx[1:0]);
      4'd2: vprdata = get_word(iv_q, idx[1:0]);
      4'd3: vprdata = get_word(dout_q, idx[1:0]);
      4'd4: begin
        case (idx[1:0])
          2'd0:    vprdata = {28'd0, irq_en_q, mode_q, 1'b0};
          2'd1:    vprdata = {28'd0, tmo_q, err_q, done_q, busy};
          2'd2:    vprdata = blkcnt_q;
          default: vprdata = 32'd0;
        endcase
      end
      default: vprdata = 32'd0;
    endcase
  end

  // Register banks, status and the load/wait sequencer with watchdog
  always_ff @(posedge vclk) begin
    if (vrst) begin
      state_q        <= S_IDLE;
      key_q          <= '0;
      din_q          <= '0;
      iv_q           <= '0;
      dout_q         <= '0;
      core_text_in_q <= '0;
      core_ld_q      <= 1'b0;
      mode_q         <= 2'b00;
      irq_en_q       <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      tmo_q          <= 1'b0;
      irq_q          <= 1'b0;
      blkcnt_q       <= '0;
      wdog_q         <= '0;
    end else begin
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      if (wr && !busy) begin
        case (idx[5:2])
          4'd0: key_q <= put_word(key_q, idx[1:0], vpwdata);
          4'd1: din_q <= put_word(din_q, idx[1:0], vpwdata);
          4'd2: iv_q  <= put_word(iv_q, idx[1:0], vpwdata);
          4'd4: if (idx[1:0] == 2'd0) mode_q <= vpwdata[2:1];
          default: ;
        endcase
      end
      case (state_q)
        S_IDLE: begin
          core_ld_q <= 1'b0;
          if (start_ok) begin
            state_q        <= S_LOAD;
            core_ld_q      <= 1'b1;
            core_text_in_q <= ld_text;
          end
        end
        S_LOAD: begin
          core_ld_q <= 1'b0;
          wdog_q    <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            dout_q   <= res_dout;
            iv_q     <= res_iv;
            blkcnt_q <= blkcnt_q + 32'd1;
            state_q  <= S_IDLE;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            state_q <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        default: begin
          core_ld_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb/tb_aes_mode_ctrl.sv - scoreboard bench for aes_mode_ctrl with a behavioural stand-in core
module tb_aes_mode_ctrl;

  localparam logic [127:0] KEYV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] NCT  = 128'h963b1f279584fbcf2732487f8f4b3aa5;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic         vclk = 1'b0;
  logic         vrst;
  logic [7:0]   vpsel;
  logic         vpenable, vpwrite;
  logic [31:0]  vpaddr, vpwdata, vprdata;
  logic         irq, core_ld, core_done;
  logic [127:0] core_key, core_text_in, core_text_out;

  typedef struct {
    string       name;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t      rd_q[$];
  logic [127:0] ld_q[$];
  logic         rd_req;
  logic         core_en;
  int           core_lat;
  int           checks = 0;
  int           errors = 0;
  int           blk = 0;

  aes_mode_ctrl #(.PINDEX(0), .NAPBSLV(8), .CTR_W(32), .TIMEOUT(8)) dut (
    .vclk(vclk), .vrst(vrst), .vpsel(vpsel), .vpenable(vpenable), .vpaddr(vpaddr),
    .vpwrite(vpwrite), .vpwdata(vpwdata), .vprdata(vprdata), .irq(irq),
    .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_text_out(core_text_out), .core_done(core_done)
  );

  always #5 vclk = ~vclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] fake_core(input logic [127:0] x);
    return (x == PT) ? CT : ~x;
  endfunction

  // Monitor: pops expectations whenever a read is presented or the core is loaded
  initial begin
    forever begin
      @(negedge vclk);
      if (rd_req) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_no_expectation addr=%h", vpaddr);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk(e.name, {96'd0, vprdata}, {96'd0, e.data});
        end
      end
      if (core_ld) begin
        if (ld_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_core_ld text_in=%h", core_text_in);
        end else begin
          logic [127:0] x;
          x = ld_q.pop_front();
          chk("core_text_in", core_text_in, x);
        end
      end
    end
  end

  // Stand-in AES core answering each load after core_lat cycles
  initial begin
    logic [127:0] cap;
    core_done = 1'b0;
    core_text_out = '0;
    forever begin
      @(negedge vclk);
      if (core_ld && core_en) begin
        cap = core_text_in;
        repeat (core_lat) @(posedge vclk);
        #1;
        core_done = 1'b1;
        core_text_out = fake_core(cap);
        @(posedge vclk);
        #1 core_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $fatal(1);
  end

  task automatic wr(input logic [5:0] i, input logic [31:0] d);
    @(posedge vclk); #1;
    vpsel = 8'h01; vpenable = 1'b1; vpwrite = 1'b1;
    vpaddr = {24'd0, i, 2'b00}; vpwdata = d;
    @(posedge vclk); #1;
    vpsel = 8'h00; vpenable = 1'b0; vpwrite = 1'b0;
  endtask

  task automatic wr128(input logic [5:0] base, input logic [127:0] v);
    wr(base,      v[127:96]);
    wr(base + 1,  v[95:64]);
    wr(base + 2,  v[63:32]);
    wr(base + 3,  v[31:0]);
  endtask

  task automatic rd(input logic [5:0] i, input logic [31:0] exp, input string name);
    rd_exp_t e;
    @(posedge vclk); #1;
    vpaddr = {24'd0, i, 2'b00};
    e.name = name; e.data = exp;
    rd_q.push_back(e);
    rd_req = 1'b1;
    @(negedge vclk); #1 rd_req = 1'b0;
  endtask

  task automatic rd128(input logic [5:0] base, input logic [127:0] v, input string name);
    rd(base,     v[127:96], {name, "0"});
    rd(base + 1, v[95:64],  {name, "1"});
    rd(base + 2, v[63:32],  {name, "2"});
    rd(base + 3, v[31:0],   {name, "3"});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge vclk);
  endtask

  initial begin
    vrst = 1'b1; vpsel = '0; vpenable = 1'b0; vpwrite = 1'b0;
    vpaddr = '0; vpwdata = '0; rd_req = 1'b0; core_en = 1'b1; core_lat = 2;
    idle(3); #1 vrst = 1'b0;

    // Reset state
    chk("rst_core_ld", {127'd0, core_ld}, 128'd0);
    chk("rst_irq", {127'd0, irq}, 128'd0);
    chk("rst_text_in", core_text_in, 128'd0);
    rd(6'd0,  32'd0, "rst_key0");
    rd(6'd16, 32'd0, "rst_ctrl");
    rd(6'd17, 32'd0, "rst_status");
    rd(6'd18, 32'd0, "rst_blkcnt");
    rd(6'd12, 32'd0, "rst_dout0");

    // ECB with FIPS-197 vector
    wr128(6'd0, KEYV);
    wr128(6'd4, PT);
    ld_q.push_back(PT);
    wr(6'd16, 32'h9);
    idle(6); blk++;
    rd128(6'd12, CT, "ecb_dout");
    rd(6'd17, 32'h2, "ecb_status");
    rd(6'd18, blk, "ecb_blkcnt");
    rd(6'd16, 32'h8, "ecb_ctrl");
    chk("ecb_irq", {127'd0, irq}, 128'd1);
    chk("core_key", core_key, KEYV);
    wr(6'd17, 32'h2);
    idle(2);
    chk("w1c_irq_low", {127'd0, irq}, 128'd0);

    // CBC, two chained blocks
    wr128(6'd8, PT);
    wr128(6'd4, 128'd0);
    ld_q.push_back(PT);
    wr(6'd16, 32'hB);
    idle(6); blk++;
    rd128(6'd12, CT, "cbc1_dout");
    rd128(6'd8, CT, "cbc1_iv");
    rd(6'd18, blk, "cbc1_blkcnt");
    ld_q.push_back(CT);
    wr(6'd16, 32'hB);
    idle(6); blk++;
    rd128(6'd12, NCT, "cbc2_dout");
    rd128(6'd8, NCT, "cbc2_iv");
    rd(6'd18, blk, "cbc2_blkcnt");

`ifdef AES_CTR_MODE_EN
    // CTR with low-word wrap then increment
    wr128(6'd8, 128'h00000000_00000000_00000000_ffffffff);
    ld_q.push_back(128'h00000000_00000000_00000000_ffffffff);
    wr(6'd16, 32'hD);
    idle(6); blk++;
    rd128(6'd8, 128'd0, "ctr1_iv");
    rd128(6'd12, 128'hffffffff_ffffffff_ffffffff_00000000, "ctr1_dout");
    ld_q.push_back(128'd0);
    wr(6'd16, 32'hD);
    idle(6); blk++;
    rd128(6'd8, 128'd1, "ctr2_iv");
    rd128(6'd12, ONES, "ctr2_dout");
    rd(6'd18, blk, "ctr_blkcnt");
`else
    // CTR not built: mode 10 is reserved
    wr(6'd16, 32'hD);
    idle(3);
    rd(6'd17, 32'h6, "ctr_off_status");
    rd(6'd18, blk, "ctr_off_blkcnt");
`endif

    // Busy protection
    wr(6'd17, 32'hE);
    core_lat = 6;
    ld_q.push_back(128'd0);
    wr(6'd16, 32'h9);
    wr(6'd7, 32'h12345678);
    wr(6'd16, 32'h9);
    idle(10); blk++;
    rd(6'd7, 32'd0, "busy_din3");
    rd(6'd17, 32'h6, "busy_status");
    rd(6'd18, blk, "busy_blkcnt");
    rd128(6'd12, ONES, "busy_dout");
    wr(6'd17, 32'h4);
    rd(6'd17, 32'h2, "busy_w1c_err");

    // Completion timeout
    wr(6'd17, 32'hE);
    core_en = 1'b0;
    ld_q.push_back(128'd0);
    wr(6'd16, 32'h9);
    idle(7);
    rd(6'd17, 32'h1, "tmo_last_wait");
    rd(6'd17, 32'hC, "tmo_status");
    rd(6'd18, blk, "tmo_blkcnt");
    @(posedge vclk); #1;
    core_done = 1'b1; core_text_out = 128'hdeadbeef;
    @(posedge vclk); #1 core_done = 1'b0;
    idle(2);
    rd(6'd12, 32'hffffffff, "late_dout0");
    rd(6'd18, blk, "late_blkcnt");
    rd(6'd17, 32'hC, "late_status");
    chk("tmo_irq", {127'd0, irq}, 128'd1);

    // Reset mid-WAIT, then reserved mode
    wr(6'd17, 32'hE);
    core_en = 1'b1;
    ld_q.push_back(128'd0);
    wr(6'd16, 32'h9);
    idle(2);
    @(posedge vclk); #1 vrst = 1'b1;
    @(posedge vclk); #1 vrst = 1'b0;
    chk("rst_mid_core_ld", {127'd0, core_ld}, 128'd0);
    idle(8);
    rd(6'd17, 32'd0, "rst_mid_status");
    rd(6'd12, 32'd0, "rst_mid_dout0");
    rd(6'd15, 32'd0, "rst_mid_dout3");
    rd(6'd18, 32'd0, "rst_mid_blkcnt");
    chk("rst_mid_key", core_key, 128'd0);
    wr(6'd16, 32'h7);
    idle(4);
    rd(6'd17, 32'h4, "rsv_status");
    rd(6'd16, 32'h6, "rsv_ctrl");
    chk("ld_queue_drained", {96'd0, 32'(ld_q.size())}, 128'd0);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
